wb_clint: RTL and testbench
===========================

# wb_clint

Core-local interruptor that answers the core's data-side Wishbone bus as a responder and generates the `timer_int` and `software_int` lines the core samples on `interrupts[7]` and `interrupts[3]`. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip`, all memory-mapped. It sits behind the address decoder on the non-SRAM slave slot, alongside the SRAM on the data bus.

## Interface
- `ADR_WIDTH`, 16: number of `adr_i` bits decoded; the upper address bits are already removed by the decoder.
- `TICK_DIV`, 1: clock cycles per `mtime` increment; legal range is 1 or more.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cyc_i`  in  1  Wishbone cycle valid.
- `stb_i`  in  1  Wishbone strobe, already qualified by the decoder select.
- `we_i`  in  1  1 = write.
- `sel_i`  in  4  byte enables; `sel_i[n]` covers `dat_i[8n+7:8n]`.
- `adr_i`  in  ADR_WIDTH  byte address; bits [1:0] are ignored.
- `dat_i`  in  32  write data.
- `dat_o`  out  32  read data, valid while `ack_o` = 1.
- `ack_o`  out  1  transfer acknowledge.
- `stall_o`  out  1  pipelined-Wishbone stall; constant 0.
- `timer_int`  out  1  machine timer interrupt, level.
- `software_int`  out  1  machine software interrupt, level.

## Operation
- Register map, word offsets:
  - 0x0000: `msip`, bit 0 only; other bits read as 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high word.
  - 0xBFF8 / 0xBFFC: `mtime` low / high word.
- Unmapped offsets: reads return 0, writes are ignored, the transfer is still acknowledged.
- Transfer acceptance: a transfer is accepted in any cycle with `cyc_i & stb_i`. `stall_o` = 0, so one transfer can be accepted every cycle.
- Writes: only the bytes with `sel_i` set are updated. A write with `sel_i` = 0 is acknowledged and has no effect.
- Prescaler: counts 0 to TICK_DIV-1 and asserts `tick` when it reaches TICK_DIV-1, then wraps to 0. When TICK_DIV = 1, `tick` is high every cycle.
- `mtime` increment: on `tick`, `mtime` increments by 1 as a 64-bit value, with carry from the low word into the high word. It wraps from 2^64-1 to 0.
- `mtime` write vs. tick: an accepted write to either `mtime` word in the same cycle as `tick` wins. The whole 64-bit increment is suppressed that cycle. The unwritten word and the unwritten bytes keep their prior value.
- Interrupts:
  - `timer_int` is the registered value of (`mtime` >= `mtimecmp`), unsigned 64-bit compare.
  - `software_int` is the registered `msip`.
- Reset values: `mtime` = 0, `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, `msip` = 0, prescaler = 0, `ack_o` = 0, `dat_o` = 0, `timer_int` = 0, `software_int` = 0.

## Timing
- Acknowledge: `ack_o` is asserted exactly one cycle after the acceptance cycle and lasts one cycle per accepted transfer. Back-to-back strobes give back-to-back acks.
- Read data: `dat_o` holds the register value sampled in the acceptance cycle, before any same-cycle update. Reading `mtime` low then high is therefore not atomic; software must re-read the high word to detect a carry.
- Write commit: a write updates the register at the end of the acceptance cycle. A read accepted in the next cycle returns the new value.
- Interrupt latency:
  - `timer_int` reflects a change to `mtime` or `mtimecmp` one cycle after the register updates, i.e. two cycles after the write is accepted.
  - `software_int` follows the `msip` write one cycle after the register updates.
- Cycle abort: if `cyc_i` = 0 in the cycle after acceptance, `ack_o` is forced to 0. A write that was already accepted is not undone.
- Reset mid-transfer: `ack_o` and all state clear immediately. No ack is issued for a transfer that was in flight.

## Structure
- Shared package `clint_pkg` holds:
  - `localparam` register offsets `MSIP_OFS`, `MTIMECMP_LO_OFS`, `MTIMECMP_HI_OFS`, `MTIME_LO_OFS`, `MTIME_HI_OFS`;
  - `MTIMECMP_RST` = 64'hFFFF_FFFF_FFFF_FFFF;
  - an interrupt-bit index enum (SW = 3, TIMER = 7, EXT = 11), shared with the core's `mip`/`mie` logic.
- One sub-module, `clint_timer`, contains the prescaler, the 64-bit `mtime` with per-byte write enables and write-over-tick priority, and the registered compare against `mtimecmp`.
- `wb_clint` contains the Wishbone decode, the ack/`dat_o` register, `mtimecmp`, `msip` and the byte-lane merge.

## Test plan
- Reset: release `rst_n`, then read 0x4000 -> ack after 1 cycle, `dat_o` = 0xFFFF_FFFF; `timer_int` = 0 and `software_int` = 0 throughout.
- `msip`: write 0x0000 with data 0x1, `sel_i` 0001 -> `software_int` rises 2 cycles after acceptance. Then write 0x0 with `sel_i` 0000 -> no change. Then write 0x0 with `sel_i` 0001 -> `software_int` falls.
- Compare, TICK_DIV = 1: write 0x4004 = 0, 0x4000 = 0x20, then 0xBFF8 = 0x10 -> `timer_int` rises 0x10 cycles after the `mtime` write plus 1 cycle. Then write 0x4000 = 0xFFFF_FFFF -> `timer_int` falls.
- Carry and write priority: write 0xBFFC = 0, 0xBFF8 = 0xFFFF_FFFE, then read 0xBFFC after 3 ticks -> 0x0000_0001. A write coincident with a tick lands exactly, with no +1.
- Byte lanes: after reset, write 0x4000 data 0xAABBCCDD with `sel_i` 0100, then read -> 0xFFBB_FFFF.
- Pipelined bus and abort: strobe 4 consecutive cycles (two unmapped reads at 0x2000, then reads at 0xBFF8 and 0x0) -> 4 consecutive acks, data 0, 0, `mtime` low, 0. Drop `cyc_i` right after a write to 0x0 -> no ack, but `msip` = 1.

Source files
------------

// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset values and interrupt bit indices shared by the CLINT and the core
package clint_pkg;
  localparam logic [15:0] MSIP_OFS        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFS    = 16'hBFFC;
  localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef enum logic [3:0] {SW = 4'd3, TIMER = 4'd7, EXT = 4'd11} irq_bit_e;
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wb_clint_if.sv
// wb_clint_if: pipelined Wishbone responder port of the CLINT
interface wb_clint_if #(parameter int ADR_WIDTH = 16);
  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [3:0]           sel_i;
  logic [ADR_WIDTH-1:0] adr_i;
  logic [31:0]          dat_i;
  logic [31:0]          dat_o;
  logic                 ack_o;
  logic                 stall_o;
  modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, input dat_o, ack_o, stall_o);
  modport slave (input cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, output dat_o, ack_o, stall_o);
endinterface

// File: rtl/clint_timer.sv
// clint_timer: prescaled 64-bit mtime with byte-lane writes over ticks, and the registered compare
module clint_timer
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [3:0]  sel,
  input  logic [31:0] wdat,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime,
  output logic        timer_int
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic          tick;
  assign tick = cnt == CW'(TICK_DIV - 1);
  // prescaler wraps to 0 on the tick cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
  // a write to either word suppresses the whole increment for that cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mtime <= '0;
    else if (wr_lo | wr_hi) mtime <= {wr_hi ? byte_merge(mtime[63:32], wdat, sel) : mtime[63:32],
                                      wr_lo ? byte_merge(mtime[31:0], wdat, sel) : mtime[31:0]};
    else if (tick) mtime <= mtime + 64'd1;
  // timer interrupt is the registered unsigned compare
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer_int <= 1'b0;
    else timer_int <= mtime >= mtimecmp;
endmodule

// File: rtl/wb_clint.sv
// wb_clint: Wishbone-mapped core-local interruptor with mtime/mtimecmp/msip
module wb_clint
  import clint_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int TICK_DIV  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_clint_if.slave     wb,
  output logic          timer_int,
  output logic          software_int
);
  logic [ADR_WIDTH-1:0] wadr;
  logic                 acc, wr, ack_q, msip;
  logic                 is_msip, is_cmp_lo, is_cmp_hi, is_mt_lo, is_mt_hi;
  logic [31:0]          rdata, dat_q;
  logic [63:0]          mtimecmp, mtime;
  assign wadr      = wb.adr_i & ~ADR_WIDTH'(3);
  assign acc       = wb.cyc_i & wb.stb_i;
  assign wr        = acc & wb.we_i;
  assign is_msip   = wadr == ADR_WIDTH'(MSIP_OFS);
  assign is_cmp_lo = wadr == ADR_WIDTH'(MTIMECMP_LO_OFS);
  assign is_cmp_hi = wadr == ADR_WIDTH'(MTIMECMP_HI_OFS);
  assign is_mt_lo  = wadr == ADR_WIDTH'(MTIME_LO_OFS);
  assign is_mt_hi  = wadr == ADR_WIDTH'(MTIME_HI_OFS);
  assign rdata = is_msip   ? {31'd0, msip} :
                 is_cmp_lo ? mtimecmp[31:0] :
                 is_cmp_hi ? mtimecmp[63:32] :
                 is_mt_lo  ? mtime[31:0] :
                 is_mt_hi  ? mtime[63:32] : 32'd0;
  assign wb.ack_o   = ack_q & wb.cyc_i;
  assign wb.dat_o   = dat_q;
  assign wb.stall_o = 1'b0;
  // ack one cycle after acceptance; read data is the pre-update register value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= rdata;
    end
  // mtimecmp and msip byte-lane writes, software interrupt registered from msip
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mtimecmp     <= MTIMECMP_RST;
      msip         <= 1'b0;
      software_int <= 1'b0;
    end else begin
      if (wr & is_cmp_lo) mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], wb.dat_i, wb.sel_i);
      if (wr & is_cmp_hi) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wb.dat_i, wb.sel_i);
      if (wr & is_msip & wb.sel_i[0]) msip <= wb.dat_i[0];
      software_int <= msip;
    end
  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_lo     (wr & is_mt_lo),
    .wr_hi     (wr & is_mt_hi),
    .sel       (wb.sel_i),
    .wdat      (wb.dat_i),
    .mtimecmp  (mtimecmp),
    .mtime     (mtime),
    .timer_int (timer_int)
  );
endmodule

// File: tb/tb_wb_clint.sv
// tb_wb_clint: directed checks of the CLINT register map, timing and interrupts
module tb_wb_clint;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timer_int, software_int;
  logic sw_at_ack;
  logic [31:0] rd;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  wb_clint_if #(.ADR_WIDTH(16)) wb ();
  wb_clint #(.ADR_WIDTH(16), .TICK_DIV(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb           (wb),
    .timer_int    (timer_int),
    .software_int (software_int)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic we, input logic [15:0] adr, input logic [3:0] sel, input logic [31:0] dat, output logic [31:0] q);
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = we;
    wb.adr_i = adr;
    wb.sel_i = sel;
    wb.dat_i = dat;
    @(posedge clk);
    #1;
    wb.stb_i = 1'b0;
    chk("ack", {31'd0, wb.ack_o}, 32'd1);
    q = wb.dat_o;
    sw_at_ack = software_int;
    @(posedge clk);
    #1;
    chk("ack_end", {31'd0, wb.ack_o}, 32'd0);
    wb.cyc_i = 1'b0;
    wb.we_i  = 1'b0;
  endtask
  task automatic wr(input logic [15:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] q;
    xfer(1'b1, adr, sel, dat, q);
  endtask
  task automatic rdv(input string tag, input logic [15:0] adr, input logic [31:0] exp);
    logic [31:0] q;
    xfer(1'b0, adr, 4'h0, 32'd0, q);
    chk(tag, q, exp);
  endtask
  initial begin
    logic [15:0] padr [4];
    logic [31:0] pexp [4];
    padr = '{16'h2000, 16'h2000, 16'hBFF8, 16'h0000};
    pexp = '{32'd0, 32'd0, 32'h103, 32'd0};
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    wb.sel_i = 4'h0;
    wb.adr_i = 16'h0;
    wb.dat_i = 32'h0;
    #12;
    chk("rst_ack", {31'd0, wb.ack_o}, 32'd0);
    chk("rst_dat", wb.dat_o, 32'd0);
    chk("rst_timer", {31'd0, timer_int}, 32'd0);
    chk("rst_sw", {31'd0, software_int}, 32'd0);
    chk("stall", {31'd0, wb.stall_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdv("cmp_lo_rst", 16'h4000, 32'hFFFF_FFFF);
    chk("timer_post_rst", {31'd0, timer_int}, 32'd0);
    chk("sw_post_rst", {31'd0, software_int}, 32'd0);
    wr(16'h0000, 4'b0001, 32'hFFFF_FFFF);
    chk("sw_lat_early", {31'd0, sw_at_ack}, 32'd0);
    chk("sw_rise", {31'd0, software_int}, 32'd1);
    rdv("msip_rd", 16'h0000, 32'd1);
    wr(16'h0000, 4'b0000, 32'd0);
    @(posedge clk);
    #1 chk("sw_sel0", {31'd0, software_int}, 32'd1);
    wr(16'h0000, 4'b0001, 32'd0);
    chk("sw_fall", {31'd0, software_int}, 32'd0);
    wr(16'h4004, 4'hF, 32'd0);
    wr(16'h4000, 4'hF, 32'h20);
    wr(16'hBFF8, 4'hF, 32'h10);
    repeat (15) @(posedge clk);
    #1 chk("timer_before", {31'd0, timer_int}, 32'd0);
    @(posedge clk);
    #1 chk("timer_rise", {31'd0, timer_int}, 32'd1);
    rdv("cmp_lo_rd", 16'h4000, 32'h20);
    wr(16'h4000, 4'hF, 32'hFFFF_FFFF);
    chk("timer_fall", {31'd0, timer_int}, 32'd0);
    wr(16'hBFFC, 4'hF, 32'd0);
    wr(16'hBFF8, 4'hF, 32'hFFFF_FFFE);
    rdv("mt_hi_pre", 16'hBFFC, 32'd0);
    rdv("mt_lo_wrap", 16'hBFF8, 32'd1);
    rdv("mt_hi_carry", 16'hBFFC, 32'd1);
    chk("timer_carry", {31'd0, timer_int}, 32'd1);
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = 1'b1;
    wb.adr_i = 16'hBFF8;
    wb.sel_i = 4'hF;
    wb.dat_i = 32'h1000;
    @(posedge clk);
    #1 wb.we_i = 1'b0;
    @(posedge clk);
    #1 chk("wr_over_tick", wb.dat_o, 32'h1000);
    wb.stb_i = 1'b0;
    @(posedge clk);
    #1 wb.cyc_i = 1'b0;
    wr(16'hBFFC, 4'b0010, 32'h0000_5500);
    rdv("mt_hi_lane", 16'hBFFC, 32'h0000_5501);
    wr(16'h0000, 4'b0001, 32'd1);
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.adr_i = 16'h4000;
    @(posedge clk);
    #1 chk("ack_pre_rst", {31'd0, wb.ack_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ack_mid_rst", {31'd0, wb.ack_o}, 32'd0);
    chk("dat_mid_rst", wb.dat_o, 32'd0);
    chk("timer_mid_rst", {31'd0, timer_int}, 32'd0);
    chk("sw_mid_rst", {31'd0, software_int}, 32'd0);
    wb.stb_i = 1'b0;
    wb.cyc_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr(16'h4000, 4'b0100, 32'hAABB_CCDD);
    rdv("cmp_lane", 16'h4000, 32'hFFBB_FFFF);
    rdv("cmp_hi_rst", 16'h4004, 32'hFFFF_FFFF);
    rdv("msip_rst", 16'h0000, 32'd0);
    wr(16'hBFF8, 4'hF, 32'h100);
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb.adr_i = padr[i];
      @(posedge clk);
      #1;
      chk($sformatf("pipe_ack%0d", i), {31'd0, wb.ack_o}, 32'd1);
      chk($sformatf("pipe_dat%0d", i), wb.dat_o, pexp[i]);
    end
    wb.stb_i = 1'b0;
    @(posedge clk);
    #1 chk("pipe_end", {31'd0, wb.ack_o}, 32'd0);
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b1;
    wb.cyc_i = 1'b1;
    wb.we_i  = 1'b1;
    wb.adr_i = 16'h0000;
    wb.sel_i = 4'b0001;
    wb.dat_i = 32'd1;
    @(posedge clk);
    #1;
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    #1 chk("ack_abort", {31'd0, wb.ack_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("ack_abort_next", {31'd0, wb.ack_o}, 32'd0);
    chk("sw_abort", {31'd0, software_int}, 32'd1);
    rdv("msip_abort", 16'h0000, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
